// File: rtl/stream_capture.sv
// rtl/stream_capture.sv - triggered sample capture buffer with bus readback
// Optional rising-zero-crossing trigger: define STREAM_CAPTURE_TRIGGER_EN.
// Without it, an armed capture starts on the first valid sample.
module stream_capture #(
  parameter int          SIG_WIDTH = 16,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] CTRL_ADDR = 32'h0,
  localparam int         ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic [SIG_WIDTH-1:0] i_cap_signal,
  input  logic                 i_cap_valid,
  input  logic [31:0]          i_cap_ctrl_reg,
  input  logic [31:0]          i_cap_lngth_reg,
  input  logic                 i_cap_write,
  input  logic [31:0]          i_cap_addrs,
  input  logic                 i_cap_read,
  output logic [SIG_WIDTH-1:0] o_cap_rdata,
  output logic                 o_cap_rvalid,
  output logic                 o_cap_busy,
  output logic                 o_cap_done,
  output logic [ADDR_W:0]      o_cap_count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [ADDR_W:0]      len_q, len_d;
  logic [ADDR_W:0]      count_inc;
  logic [SIG_WIDTH-1:0] mem [DEPTH];
  logic [SIG_WIDTH-1:0] rdata_q;
  logic                 rvalid_q;
  logic                 cmd, do_abort, do_arm, trig, wr_en;
  logic                 unused_ok;

  assign cmd       = i_cap_write && (i_cap_addrs == CTRL_ADDR);
  assign do_abort  = cmd && i_cap_ctrl_reg[1];
  assign do_arm    = cmd && i_cap_ctrl_reg[0] && !i_cap_ctrl_reg[1];
  assign count_inc = count_q + 1'b1;
  assign unused_ok = ^i_cap_ctrl_reg[31:2];

`ifdef STREAM_CAPTURE_TRIGGER_EN
  logic [SIG_WIDTH-1:0] prev_q, prev_d;
  // Rising zero crossing: current sample non-negative, previous valid sample negative.
  assign trig = i_cap_valid && !i_cap_signal[SIG_WIDTH-1] && prev_q[SIG_WIDTH-1];

  // Previous valid sample, cleared on ARM so the first sample cannot trigger.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) prev_q <= '0;
    else       prev_q <= prev_d;
  end
`else
  assign trig = i_cap_valid;
`endif

  // Next-state logic: abort has priority, ARM only from IDLE/DONE, store while capturing.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    wr_en   = 1'b0;
`ifdef STREAM_CAPTURE_TRIGGER_EN
    prev_d  = prev_q;
`endif
    if (do_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (do_arm) begin
            state_d = S_ARMED;
            count_d = '0;
            if (i_cap_lngth_reg == 32'd0 || i_cap_lngth_reg > 32'(DEPTH))
              len_d = DEPTH_C;
            else
              len_d = i_cap_lngth_reg[ADDR_W:0];
`ifdef STREAM_CAPTURE_TRIGGER_EN
            prev_d  = '0;
`endif
          end
        end
        S_ARMED: begin
          // The triggering sample is stored at index 0 (count is 0 here).
          if (trig) begin
            wr_en   = 1'b1;
            count_d = count_inc;
            state_d = (count_inc == len_q) ? S_DONE : S_CAPTURE;
          end
`ifdef STREAM_CAPTURE_TRIGGER_EN
          if (i_cap_valid) prev_d = i_cap_signal;
`endif
        end
        S_CAPTURE: begin
          if (i_cap_valid) begin
            wr_en   = 1'b1;
            count_d = count_inc;
            if (count_inc == len_q) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state, sample count and latched length.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= DEPTH_C;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // Capture memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[ADDR_W-1:0]] <= i_cap_signal;
  end

  // Registered read port: data and pulse one cycle after each strobe.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= i_cap_read;
      if (i_cap_read) rdata_q <= mem[i_cap_addrs[ADDR_W-1:0]];
    end
  end

  assign o_cap_rdata  = rdata_q;
  assign o_cap_rvalid = rvalid_q;
  assign o_cap_busy   = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign o_cap_done   = (state_q == S_DONE);
  assign o_cap_count  = count_q;

endmodule

// File: tb/tb_stream_capture.sv
// tb/tb_stream_capture.sv - scoreboard bench for stream_capture
module tb_stream_capture;
  localparam int          SW = 16;
  localparam int          DP = 16;
  localparam int          AW = $clog2(DP);
  localparam logic [31:0] CA = 32'h40;

  logic          clk = 1'b0;
  logic          a_rst;
  logic [SW-1:0] i_cap_signal;
  logic          i_cap_valid;
  logic [31:0]   i_cap_ctrl_reg;
  logic [31:0]   i_cap_lngth_reg;
  logic          i_cap_write;
  logic [31:0]   i_cap_addrs;
  logic          i_cap_read;
  logic [SW-1:0] o_cap_rdata;
  logic          o_cap_rvalid;
  logic          o_cap_busy;
  logic          o_cap_done;
  logic [AW:0]   o_cap_count;

  stream_capture #(.SIG_WIDTH(SW), .DEPTH(DP), .CTRL_ADDR(CA)) dut (
    .clk(clk), .a_rst(a_rst),
    .i_cap_signal(i_cap_signal), .i_cap_valid(i_cap_valid),
    .i_cap_ctrl_reg(i_cap_ctrl_reg), .i_cap_lngth_reg(i_cap_lngth_reg),
    .i_cap_write(i_cap_write), .i_cap_addrs(i_cap_addrs), .i_cap_read(i_cap_read),
    .o_cap_rdata(o_cap_rdata), .o_cap_rvalid(o_cap_rvalid),
    .o_cap_busy(o_cap_busy), .o_cap_done(o_cap_done), .o_cap_count(o_cap_count)
  );

  typedef struct { logic [SW-1:0] data; int cyc; } exp_t;
  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop the oldest expected read whenever rvalid is seen.
  always @(negedge clk) begin
    if (o_cap_rvalid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL rvalid_unexpected: got rvalid=1 expected 0 at cycle %0d", cyc);
      end else begin
        me = sb.pop_front();
        check("rdata", int'(o_cap_rdata), int'(me.data));
        check("rvalid_cycle", cyc, me.cyc);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      total++; bad++;
      $display("FAIL rvalid_missing: got rvalid=0 expected 1 at cycle %0d", me.cyc);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [31:0] addr, input logic [31:0] ctrl, input logic [31:0] len);
    i_cap_write = 1'b1; i_cap_addrs = addr; i_cap_ctrl_reg = ctrl; i_cap_lngth_reg = len;
    tick;
    i_cap_write = 1'b0; i_cap_addrs = '0;
  endtask

  task automatic send(input int v);
    i_cap_valid = 1'b1; i_cap_signal = SW'(v);
    tick;
    i_cap_valid = 1'b0; i_cap_signal = 16'hDEAD;
  endtask

  task automatic rd(input int idx, input int exp);
    exp_t e;
    e.data = SW'(exp);
    e.cyc  = cyc + 1;
    i_cap_read = 1'b1; i_cap_addrs = 32'(idx);
    sb.push_back(e);
    tick;
    i_cap_read = 1'b0; i_cap_addrs = '0;
  endtask

  task automatic prime;
`ifdef STREAM_CAPTURE_TRIGGER_EN
    send(-1);
`endif
  endtask

  task automatic status(input string tag, input int busy, input int done, input int count);
    check({tag, "_busy"},  int'(o_cap_busy),  busy);
    check({tag, "_done"},  int'(o_cap_done),  done);
    check({tag, "_count"}, int'(o_cap_count), count);
  endtask

  initial begin
    a_rst = 1'b1; i_cap_signal = '0; i_cap_valid = 1'b0; i_cap_ctrl_reg = '0;
    i_cap_lngth_reg = '0; i_cap_write = 1'b0; i_cap_addrs = '0; i_cap_read = 1'b0;
    #2;
    status("reset", 0, 0, 0);
    check("reset_rvalid", int'(o_cap_rvalid), 0);
    check("reset_rdata", int'(o_cap_rdata), 0);
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    tick;

    // Length 4 capture with a valid-low gap, extra sample dropped
    cmd(CA, 32'h1, 32'd4);
    status("armed", 1, 0, 0);
    prime;
    send(10);
    status("cap1", 1, 0, 1);
    tick;
    send(20); send(30); send(40);
    status("len4_done", 0, 1, 4);
    send(50);
    status("after_done", 0, 1, 4);
    cmd(32'h44, 32'h1, 32'd4);
    status("other_addr", 0, 1, 4);
    for (int i = 0; i < 4; i++) rd(i, (i + 1) * 10);
    tick; tick;

`ifdef STREAM_CAPTURE_TRIGGER_EN
    cmd(CA, 32'h1, 32'd2);
    send(-5); send(-1);
    status("trig_wait", 1, 0, 0);
    send(3); send(7);
    status("trig_done", 0, 1, 2);
    send(9);
    rd(0, 3); rd(1, 7);
    tick; tick;
`endif

    // Length 0 means full depth
    cmd(CA, 32'h1, 32'd0);
    prime;
    for (int i = 0; i < DP; i++) send(100 + i);
    send(999);
    status("len0", 0, 1, DP);
    rd(15, 115);
    tick;
    rd(1, 101); rd(2, 102);
    tick; tick;

    // ARM+ABORT in one write during capture
    cmd(CA, 32'h1, 32'd8);
    prime;
    send(200); send(201); send(202);
    status("pre_abort", 1, 0, 3);
    cmd(CA, 32'h3, 32'd8);
    status("abort", 0, 0, 3);
    send(203);
    status("idle_drop", 0, 0, 3);
    rd(3, 103);
    tick; tick;

    // Asynchronous reset mid-capture, then re-arm
    cmd(CA, 32'h1, 32'd8);
    prime;
    send(300); send(301);
    status("pre_rst", 1, 0, 2);
    rd(0, 300);
    @(negedge clk); #1;
    a_rst = 1'b1;
    #1;
    status("rst_mid", 0, 0, 0);
    check("rst_mid_rvalid", int'(o_cap_rvalid), 0);
    check("rst_mid_rdata", int'(o_cap_rdata), 0);
    @(negedge clk);
    a_rst = 1'b0;
    tick;
    status("post_rst", 0, 0, 0);
    cmd(CA, 32'h1, 32'd2);
    prime;
    send(400); send(401);
    status("rearm", 0, 1, 2);
    rd(0, 400); rd(1, 401);
    repeat (4) tick;
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/stream_capture.md
STREAM_CAPTURE -- requirements
Module: stream_capture

Interface
REQ-001 Parameter SIG_WIDTH, default 16, width of the captured sample stream.
REQ-002 Parameter DEPTH, default 256, capture memory depth in samples, power of two; ADDR_W = log2(DEPTH).
REQ-003 Parameter CTRL_ADDR, default 32'h0, bus address whose write is decoded as a capture command.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 a_rst  in  1  asynchronous, active-high reset.
REQ-006 i_cap_signal  in  SIG_WIDTH  signed two's-complement sample from the DDS stream source.
REQ-007 i_cap_valid  in  1  sample qualifier; one sample per high cycle.
REQ-008 i_cap_ctrl_reg  in  32  control register; bit0 ARM, bit1 ABORT.
REQ-009 i_cap_lngth_reg  in  32  requested capture length; bits [ADDR_W:0] used.
REQ-010 i_cap_write  in  1  bus write strobe.
REQ-011 i_cap_addrs  in  32  bus address; command decode on write, sample index on read.
REQ-012 i_cap_read  in  1  bus read strobe.
REQ-013 o_cap_rdata  out  SIG_WIDTH  read sample data.
REQ-014 o_cap_rvalid  out  1  one-cycle pulse qualifying o_cap_rdata.
REQ-015 o_cap_busy  out  1  high in ARMED or CAPTURE.
REQ-016 o_cap_done  out  1  high in DONE.
REQ-017 o_cap_count  out  ADDR_W+1  samples stored in current/last capture.

Function
REQ-018 FSM states IDLE, ARMED, CAPTURE, DONE; command = i_cap_write high with i_cap_addrs == CTRL_ADDR, evaluated each clk edge.
REQ-019 Command with bit1 set -> IDLE from any state, count unchanged; ABORT wins over simultaneous ARM.
REQ-020 Command with ARM only in IDLE or DONE -> ARMED, count cleared to 0, length latched; ignored in ARMED/CAPTURE.
REQ-021 Latched length: 0 or > DEPTH -> DEPTH; otherwise value of bits [ADDR_W:0].
REQ-022 ARMED -> CAPTURE per trigger rule (Configuration); triggering sample is stored as index 0.
REQ-023 CAPTURE: each i_cap_valid cycle writes i_cap_signal to memory[count], count increments; no write when valid low.
REQ-024 CAPTURE -> DONE on the cycle the stored count reaches latched length; further valid samples dropped.
REQ-025 Read: i_cap_read samples memory[i_cap_addrs[ADDR_W-1:0]]; o_cap_rdata and o_cap_rvalid update exactly one cycle later; back-to-back reads each pulse rvalid.
REQ-026 Reads permitted in any state; read of a location written the same cycle returns the old content.
REQ-027 o_cap_rdata holds its last value while o_cap_rvalid low.
REQ-028 Writes to addresses other than CTRL_ADDR have no effect.

Reset
REQ-029 a_rst high forces IDLE, count 0, latched length DEPTH, o_cap_rdata 0, o_cap_rvalid 0, busy 0, done 0, immediately and independent of clk.
REQ-030 Memory contents are not reset; reset mid-capture discards progress.

Configuration
REQ-031 Macro STREAM_CAPTURE_TRIGGER_EN defined: ARMED waits for a rising zero crossing, i.e. a valid sample >= 0 whose previous valid sample was < 0; previous-sample register cleared on ARM.
REQ-032 Macro undefined: ARMED -> CAPTURE unconditionally on the first i_cap_valid sample after arming; no previous-sample register.

Verification
REQ-033 Length 4, no trigger macro, ARM then valid samples 10,20,30,40,50 -> done high after 40, count 4, reads 0..3 return 10,20,30,40.
REQ-034 Trigger macro, length 2, samples -5,-1,3,7,9 -> memory[0]=3, memory[1]=7, count 2.
REQ-035 Length 0 -> capture stops only at DEPTH samples, count = DEPTH.
REQ-036 ARM and ABORT in same write during CAPTURE -> IDLE, busy 0, count frozen.
REQ-037 a_rst asserted after 2 of 8 samples -> all outputs at reset values same cycle; re-ARM captures from index 0.
REQ-038 Reads at indices 1,2 on consecutive cycles -> rvalid high two consecutive cycles, one cycle after each strobe, correct data.
